// File: rtl/bcp_clause_pending_queue.sv
// Pending-clause queue for the BCP unit.
// Watch-list walker requests set/clear one bit of a registered mask.
// The clause evaluator drains set bits lowest index first via valid/ready.
module bcp_clause_pending_queue #(
    parameter int CLAUSE_NUM     = 8,
    parameter int CLAUSE_NUM_LOG = $clog2(CLAUSE_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CLAUSE_NUM_LOG-1:0] in_idx,
    input  logic                      in_op,
    input  logic                      flush,
    output logic                      pop_valid,
    input  logic                      pop_ready,
    output logic [CLAUSE_NUM_LOG-1:0] pop_idx,
    output logic [CLAUSE_NUM-1:0]     mask_out,
    output logic [CLAUSE_NUM_LOG:0]   pending_cnt,
    output logic                      err_range,
    input  logic                      err_clr
);

    localparam logic [CLAUSE_NUM_LOG:0] CNT_ONE = (CLAUSE_NUM_LOG + 1)'(1);

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [CLAUSE_NUM_LOG-1:0] lowest_idx(input logic [CLAUSE_NUM-1:0] m);
        logic [CLAUSE_NUM_LOG-1:0] r;
        r = '0;
        for (int i = CLAUSE_NUM - 1; i >= 0; i--) begin
            if (m[i]) r = CLAUSE_NUM_LOG'(i);
        end
        return r;
    endfunction

    // Number of set bits.
    function automatic logic [CLAUSE_NUM_LOG:0] popcount(input logic [CLAUSE_NUM-1:0] m);
        logic [CLAUSE_NUM_LOG:0] c;
        c = '0;
        for (int i = 0; i < CLAUSE_NUM; i++) begin
            if (m[i]) c = c + CNT_ONE;
        end
        return c;
    endfunction

    // One-hot decode; all-zero when the index is beyond the mask.
    function automatic logic [CLAUSE_NUM-1:0] decode(input logic [CLAUSE_NUM_LOG-1:0] idx);
        logic [CLAUSE_NUM-1:0] d;
        d = '0;
        for (int i = 0; i < CLAUSE_NUM; i++) begin
            d[i] = (idx == CLAUSE_NUM_LOG'(i));
        end
        return d;
    endfunction

    logic                    req_acc;
    logic                    pop_acc;
    logic                    in_range;
    logic [CLAUSE_NUM-1:0]   in_oh;
    logic [CLAUSE_NUM-1:0]   pop_oh;
    logic [CLAUSE_NUM-1:0]   mask_nxt;
    logic [CLAUSE_NUM_LOG:0] cnt_nxt;

    assign in_ready  = ~flush;
    assign pop_valid = |mask_out;
    assign pop_idx   = lowest_idx(mask_out);
    assign req_acc   = in_valid & in_ready;
    assign pop_acc   = pop_valid & pop_ready;
    assign in_oh     = decode(in_idx);
    assign in_range  = |in_oh;
    assign pop_oh    = decode(pop_idx);

    // Next mask: pop clears, then request clear, then request set (set wins, re-queues).
    always_comb begin
        mask_nxt = mask_out;
        if (pop_acc) mask_nxt = mask_nxt & ~pop_oh;
        if (req_acc && !in_op) mask_nxt = mask_nxt & ~in_oh;
        if (req_acc && in_op) mask_nxt = mask_nxt | in_oh;
        if (flush) mask_nxt = '0;
        cnt_nxt = popcount(mask_nxt);
    end

    // Mask and its popcount are registered together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_out    <= '0;
            pending_cnt <= '0;
        end else begin
            mask_out    <= mask_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    // Sticky range error; a new out-of-range request beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else if (req_acc && !in_range) begin
            err_range <= 1'b1;
        end else if (err_clr) begin
            err_range <= 1'b0;
        end
    end

endmodule

// File: doc/bcp_clause_pending_queue.md
# bcp_clause_pending_queue

Parametrised successor to the BCP unit's clause index decoder. It decodes a stream of clause indices into a registered, accumulating pending-clause mask of width CLAUSE_NUM. Each index sets or clears one bit. The BCP engine drains the pending clauses one at a time, lowest index first, through a valid/ready pop port. It sits between the watch-list walker, which produces clause indices, and the clause evaluator, which consumes them.

## Interface
- CLAUSE_NUM, default 8: number of clauses tracked, i.e. the mask width; any value ≥ 2, need not be a power of two.
- CLAUSE_NUM_LOG, default $clog2(CLAUSE_NUM): index width; derived, never overridden.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  index request valid.
- in_ready  out  1  request accepted this cycle; equals ~flush.
- in_idx  in  CLAUSE_NUM_LOG  clause index to decode.
- in_op  in  1  1 = set bit (mark pending), 0 = clear bit (cancel).
- flush  in  1  synchronous clear of the whole mask.
- pop_valid  out  1  at least one pending clause; equals |mask_out.
- pop_ready  in  1  consumer takes pop_idx this cycle.
- pop_idx  out  CLAUSE_NUM_LOG  index of the lowest set bit of mask_out; 0 when mask is empty.
- mask_out  out  CLAUSE_NUM  registered pending mask.
- pending_cnt  out  CLAUSE_NUM_LOG+1  registered popcount of mask_out.
- err_range  out  1  sticky: an accepted in_idx was ≥ CLAUSE_NUM.
- err_clr  in  1  synchronous clear of err_range.

## Operation
- Request accept: in_valid & in_ready.
- Pop accept: pop_valid & pop_ready.
- Next-mask computation, from the current mask:
  1. Pop accept clears bit pop_idx.
  2. Accepted request with in_op=0 clears bit in_idx.
  3. Accepted request with in_op=1 sets bit in_idx. Set is applied last, so a set of the same bit being popped wins and the clause is re-queued.
- Request and pop on different bits both take effect in the same cycle.
- Setting an already-set bit, or clearing an unset bit: mask unchanged, no error.
- Out-of-range: accepted in_idx ≥ CLAUSE_NUM leaves the mask untouched and sets err_range. Only reachable when CLAUSE_NUM is not a power of two.
- err_range is sticky. err_clr clears it. If err_clr and a new out-of-range request occur in the same cycle, the set wins.
- flush: next mask = 0, regardless of any pop or request that cycle. in_ready=0 during flush, so no request is accepted. A pop handshake during flush is still legal and simply lost in the clear. flush does not touch err_range.
- pending_cnt is computed from the next mask and registered alongside it, so it always matches mask_out in the same cycle.
- pop_idx comes from a combinational lowest-set-bit priority encoder over mask_out.

## Timing
- Reset values (asynchronous, immediate on rst_n low): mask_out=0, pending_cnt=0, err_range=0. Hence pop_valid=0, pop_idx=0, in_ready=~flush.
- Deasserting rst_n mid-stream discards all pending clauses. The first handshake is accepted on the first rising edge after deassertion.
- Request to mask_out latency: 1 cycle. A bit set at edge N is visible at pop_idx from edge N onward if it is the lowest.
- Pop handshake at edge N: the bit is gone and pop_idx advances to the next-lowest bit after edge N, so back-to-back pops take one per cycle with no bubble.
- The pop path (mask_out → pop_idx/pop_valid) is combinational. pop_ready may depend combinationally on pop_valid, but pop_valid never depends on pop_ready.
- in_ready depends only on flush, never on in_valid.
- Empty: pop_valid=0, pop_idx=0. A pop_ready asserted while empty is ignored.
- Full: all bits set, pending_cnt=CLAUSE_NUM. Further sets are absorbed with no overflow.

## Test plan
- Reset then sets of idx 5, 2, 7 on consecutive cycles -> mask_out=8'b1010_0100, pending_cnt=3; pops return 2, 5, 7 on three consecutive cycles, then pop_valid=0 and pending_cnt=0.
- mask=8'b0000_1000 with pop_ready=1 and a set of idx 3 in the same cycle -> mask stays 8'b0000_1000 and pending_cnt stays 1; a pop of 3 with a set of idx 6 -> mask=8'b0100_0000.
- Set all 8 bits, then repeat set of idx 4 and clear of unset... (mask full) -> pending_cnt=8 and unchanged by the repeat set; clear of idx 0 -> pending_cnt=7, pop_idx=1.
- CLAUSE_NUM=6: set idx 6 -> mask unchanged, err_range=1 and held after flush; err_clr -> 0; err_clr together with set idx 7 -> err_range=1.
- Mask=8'b1111_0000, flush with in_valid=1 set idx 0 and pop_ready=1 -> in_ready=0, next mask=0, pending_cnt=0.
- Async reset pulse mid-drain (mask=8'b0011_0000, no clock edge) -> mask_out=0, pop_valid=0 immediately; after release, set idx 1 -> pop_idx=1 next cycle.
